expr_stream_gen: RTL and testbench

//  Producer side of the ASCII expression stream consumed by the string2 recognizer.

---
 rtl/expr_stream_gen_if.sv | 11 +
 rtl/expr_stream_gen.sv | 129 ++++++++++++
 tb/tb_expr_stream_gen.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/expr_stream_gen_if.sv
// Character stream from the expression generator to its consumer.
// One character moves on every posedge where out_valid && out_ready. While out_valid is
// high and out_ready is low, the producer holds out_char stable and does not drop out_valid.
interface expr_stream_gen_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;

    modport master (output out_valid, output out_char, input out_ready);
    modport slave  (input out_valid, input out_char, output out_ready);
endinterface

// File: rtl/expr_stream_gen.sv
// Pseudo-random generator of well-formed ASCII expressions ('1'-'8', '+', '*', parens),
// emitted one character per transfer and terminated by a space.
module expr_stream_gen #(
    parameter int          MAX_DEPTH = 3,
    parameter int          MAX_LEN   = 32,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         DW        = (MAX_DEPTH < 1) ? 1 : $clog2(MAX_DEPTH + 1),
    localparam int         CW        = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                start,
    expr_stream_gen_if.master   stream,
    output logic                busy,
    output logic                done,
    output logic [DW-1:0]       depth,
    output logic [1:0]          state_dbg
);

    // OPND/OPTR name the rule set used for the next character; TERM means ' ' is presented.
    typedef enum logic [1:0] {IDLE, OPND, OPTR, TERM} state_t;

    typedef struct packed {
        logic [7:0] ch;
        state_t     nxt;
    } pick_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_nx;
    logic [CW-1:0] cnt;
    logic [DW-1:0] depth_nx;
    logic          xfer;
    pick_t         first_pick;
    pick_t         next_pick;

    // c+d+4 / c+d+3 / c+3 keep enough room to close every open paren and still end in budget.
    function automatic pick_t pick(input state_t rule, input int c, input int d,
                                   input logic [15:0] l);
        pick_t p;
        p.ch  = 8'h20;
        p.nxt = TERM;
        if (rule == OPND) begin
            if (l[0] && d < MAX_DEPTH && c + d + 4 <= MAX_LEN) begin
                p.ch  = 8'h28;
                p.nxt = OPND;
            end else begin
                p.ch  = 8'h31 + {5'd0, l[3:1]};
                p.nxt = OPTR;
            end
        end else begin
            if (d > 0 && (l[1] || c + d + 3 > MAX_LEN)) begin
                p.ch  = 8'h29;
                p.nxt = OPTR;
            end else if (d == 0 && (l[2:1] == 2'b00 || c + 3 > MAX_LEN)) begin
                p.ch  = 8'h20;
                p.nxt = TERM;
            end else begin
                p.ch  = l[2] ? 8'h2A : 8'h2B;
                p.nxt = OPND;
            end
        end
        return p;
    endfunction

    assign lfsr_nx   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign xfer      = stream.out_valid && stream.out_ready;
    assign state_dbg = state;

    always_comb begin
        depth_nx = depth;
        if (stream.out_char == 8'h28)      depth_nx = depth + DW'(1);
        else if (stream.out_char == 8'h29) depth_nx = depth - DW'(1);
    end

    always_comb begin
        first_pick = pick(OPND, 0, 0, lfsr);
        next_pick  = pick(state, int'(cnt) + 1, int'(depth_nx), lfsr);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state            <= IDLE;
            lfsr             <= SEED;
            cnt              <= '0;
            depth            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_char  <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        stream.out_char  <= first_pick.ch;
                        stream.out_valid <= 1'b1;
                        state            <= first_pick.nxt;
                        lfsr             <= lfsr_nx;
                        busy             <= 1'b1;
                        cnt              <= '0;
                        depth            <= '0;
                    end
                end
                TERM: begin
                    if (xfer) begin
                        stream.out_valid <= 1'b0;
                        busy             <= 1'b0;
                        done             <= 1'b1;
                        state            <= IDLE;
                        cnt              <= '0;
                        depth            <= '0;
                    end
                end
                default: begin
                    // Next character is loaded in the same edge that accepts the current one.
                    if (xfer) begin
                        depth           <= depth_nx;
                        cnt             <= cnt + CW'(1);
                        stream.out_char <= next_pick.ch;
                        state           <= next_pick.nxt;
                        lfsr            <= lfsr_nx;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expr_stream_gen.sv
// Bench for expr_stream_gen: three parameterisations run against a string-level model
// of the expression rules, plus reset and literal checks on the default instance.
module tb_expr_stream_gen;
  localparam int NI = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk;
  logic rst_n;
  logic start_s[NI];
  logic ready_s[NI];
  logic valid_s[NI];
  logic busy_s[NI];
  logic done_s[NI];
  logic [7:0] char_s[NI];
  logic [1:0] depth_s[NI];
  logic [1:0] state_s[NI];

  int n_cmp;
  int n_fail;
  bit go;

  // scoreboard state per instance
  logic [7:0]  exp_q[NI][$];
  logic [15:0] m_lfsr[NI];
  bit          m_busy[NI];
  bit          m_done[NI];
  int          m_depth[NI];
  bit          stalled[NI];
  logic [7:0]  prev_char[NI];
  string       cur_s[NI];
  int          n_expr[NI];

  function automatic int md_of(input int k);
    return (k == 1) ? 0 : 3;
  endfunction

  function automatic int ml_of(input int k);
    return (k == 0) ? 32 : (k == 1) ? 4 : 8;
  endfunction

  function automatic int runs_of(input int k);
    return (k == 0) ? 300 : (k == 1) ? 1000 : 400;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GMD = (g == 1) ? 0 : 3;
    localparam int GML = (g == 0) ? 32 : (g == 1) ? 4 : 8;
    localparam int GDW = (GMD < 1) ? 1 : $clog2(GMD + 1);
    expr_stream_gen_if sif();
    logic [GDW-1:0] dep;
    logic [1:0] st;
    logic b;
    logic dn;
    expr_stream_gen #(.MAX_DEPTH(GMD), .MAX_LEN(GML), .SEED(SEED)) u_dut (
      .clk(clk), .clr_n(rst_n), .start(start_s[g]), .stream(sif.master),
      .busy(b), .done(dn), .depth(dep), .state_dbg(st)
    );
    assign sif.out_ready = ready_s[g];
    assign valid_s[g] = sif.out_valid;
    assign char_s[g]  = sif.out_char;
    assign busy_s[g]  = b;
    assign done_s[g]  = dn;
    assign depth_s[g] = 2'(dep);
    assign state_s[g] = st;
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=\"%s\" required=\"%s\"", name, act, req);
    end
  endtask

  // Reference: build one whole expression from the generation rules.
  function automatic string model_expr(input int md, input int ml, inout logic [15:0] l);
    string s;
    int c;
    int d;
    bit opnd;
    bit fin;
    logic [7:0] ch;
    s = ""; c = 0; d = 0; opnd = 1'b1; fin = 1'b0;
    while (!fin) begin
      if (opnd) begin
        if (l[0] && d < md && c + d + 4 <= ml) begin ch = "("; d++; end
        else begin ch = 8'h31 + {5'd0, l[3:1]}; opnd = 1'b0; end
      end else begin
        if (d > 0 && (l[1] || c + d + 3 > ml)) begin ch = ")"; d--; end
        else if (d == 0 && (l[2:1] == 2'b00 || c + 3 > ml)) begin ch = " "; fin = 1'b1; end
        else begin ch = l[2] ? "*" : "+"; opnd = 1'b1; end
      end
      s = $sformatf("%s%c", s, ch);
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      c++;
    end
    return s;
  endfunction

  // 0 when s is a balanced, in-budget, well-formed expression ending in ' '.
  function automatic int shape_err(input string s, input int md, input int ml);
    int d;
    logic [7:0] p;
    logic [7:0] ch;
    d = 0; p = 8'h00;
    if (s.len() == 0 || s.len() > ml) return 1;
    ch = s[s.len() - 1];
    if (ch != " ") return 2;
    for (int i = 0; i < s.len() - 1; i++) begin
      ch = s[i];
      if (ch == "(") begin
        d++;
        if (d > md) return 3;
      end else if (ch == ")") begin
        if (d == 0) return 4;
        if (p == "(") return 5;
        d--;
      end else if (ch == "+" || ch == "*") begin
        if (p == 8'h00 || p == "+" || p == "*" || p == "(") return 6;
      end else if (ch < "1" || ch > "8") begin
        return 7;
      end
      p = ch;
    end
    if (d != 0) return 8;
    return 0;
  endfunction

  // compare process
  always @(negedge clk) begin
    logic [7:0] ch;
    if (go) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("valid%0d", i), 32'(valid_s[i]), 32'(m_busy[i]));
        chk($sformatf("busy%0d", i), 32'(busy_s[i]), 32'(m_busy[i]));
        chk($sformatf("done%0d", i), 32'(done_s[i]), 32'(m_done[i]));
        chk($sformatf("depth%0d", i), 32'(depth_s[i]), 32'(m_depth[i]));
        if (m_busy[i] && valid_s[i]) begin
          if (exp_q[i].size() == 0) chk($sformatf("queue%0d", i), 32'd0, 32'd1);
          else chk($sformatf("char%0d", i), 32'(char_s[i]), 32'(exp_q[i][0]));
          if (stalled[i]) chk($sformatf("stall_hold%0d", i), 32'(char_s[i]), 32'(prev_char[i]));
        end
        m_done[i]    = 1'b0;
        stalled[i]   = m_busy[i] && valid_s[i] && !ready_s[i];
        prev_char[i] = char_s[i];
        if (m_busy[i] && valid_s[i] && ready_s[i] && exp_q[i].size() > 0) begin
          ch = exp_q[i].pop_front();
          if (ch == "(") m_depth[i]++;
          else if (ch == ")") m_depth[i]--;
          cur_s[i] = $sformatf("%s%c", cur_s[i], ch);
          if (ch == " ") begin
            chk($sformatf("shape%0d", i), 32'(shape_err(cur_s[i], md_of(i), ml_of(i))), 32'd0);
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
            cur_s[i]  = "";
            n_expr[i]++;
          end
        end else if (!m_busy[i] && start_s[i]) begin
          m_busy[i] = 1'b1;
        end
      end
    end
  end

  // driver: one expression per iteration, random stalls and stray starts while busy
  task automatic drive(input int k, input int n, input bit rnd);
    string s;
    int cyc;
    for (int e = 0; e < n; e++) begin
      s = model_expr(md_of(k), ml_of(k), m_lfsr[k]);
      for (int j = 0; j < s.len(); j++) exp_q[k].push_back(s[j]);
      start_s[k] = 1'b1;
      @(posedge clk); #1;
      start_s[k] = 1'b0;
      cyc = 0;
      while (!done_s[k] && cyc < 400) begin
        ready_s[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start_s[k] = ($urandom_range(0, 7) == 0);
        @(posedge clk); #1;
        cyc++;
      end
      start_s[k] = 1'b0;
      if (!done_s[k]) begin
        chk($sformatf("timeout%0d", k), 32'(cyc), 32'd0);
        break;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    string s;
    logic [15:0] l;
    int cyc;
    n_cmp = 0; n_fail = 0; go = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin start_s[i] = 1'b0; ready_s[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(valid_s[i]), 32'd0);
      chk($sformatf("rst_busy%0d", i), 32'(busy_s[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(done_s[i]), 32'd0);
      chk($sformatf("rst_depth%0d", i), 32'(depth_s[i]), 32'd0);
      chk($sformatf("rst_char%0d", i), 32'(char_s[i]), 32'h00);
      chk($sformatf("rst_state%0d", i), 32'(state_s[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // hand-derived first expressions from SEED
    l = SEED;
    s = model_expr(3, 32, l);
    chk_str("model_default_prefix", s.substr(0, 8), "(1+7)*((3");
    l = SEED;
    s = model_expr(0, 4, l);
    chk_str("model_len4_first", s, "1 ");

    // stall on the first char, then reset in the middle of the expression
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    chk("first_valid", 32'(valid_s[0]), 32'd1);
    chk("first_char", 32'(char_s[0]), 32'h28);
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_char", 32'(char_s[0]), 32'h28);
    end
    ready_s[0] = 1'b1;
    @(posedge clk); #1;
    chk("second_char", 32'(char_s[0]), 32'h31);
    chk("depth_after_paren", 32'(depth_s[0]), 32'd1);
    @(posedge clk); #1;
    chk("third_char", 32'(char_s[0]), 32'h2B);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_s[0]), 32'd0);
    chk("midrst_busy", 32'(busy_s[0]), 32'd0);
    chk("midrst_depth", 32'(depth_s[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    s = ""; cyc = 0;
    while (!done_s[0] && cyc < 100) begin
      if (valid_s[0]) s = $sformatf("%s%c", s, char_s[0]);
      @(posedge clk); #1;
      cyc++;
    end
    l = SEED;
    chk_str("post_reset_stream", s, model_expr(3, 32, l));
    chk("done_pulse", 32'(done_s[0]), 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done_s[0]), 32'd0);
    ready_s[0] = 1'b0;
    reset_pulse();

    // randomized runs on all three instances against the scoreboard
    for (int k = 0; k < NI; k++) begin
      m_lfsr[k] = SEED; m_busy[k] = 1'b0; m_done[k] = 1'b0; m_depth[k] = 0;
      stalled[k] = 1'b0; prev_char[k] = 8'h00; cur_s[k] = ""; n_expr[k] = 0;
      exp_q[k].delete();
    end
    go = 1'b1;
    for (int k = 0; k < NI; k++) begin
      automatic int kk = k;
      fork
        drive(kk, runs_of(kk), kk != 1);
      join_none
    end
    wait fork;
    repeat (3) @(posedge clk);
    #1;
    go = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("expr_count%0d", k), 32'(n_expr[k]), 32'(runs_of(k)));
      chk($sformatf("queue_left%0d", k), 32'(exp_q[k].size()), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
